// File: rtl/m_bp_pkg.sv
// Shared widths, in-flight queue entry layout and PC field extraction for
// the fetch-side branch predictor.
package m_bp_pkg;
  localparam int BP_XLEN   = 32;
  localparam int BP_IDXW   = 5;
  localparam int BP_TAGW   = 8;
  localparam int BP_QDEPTH = 4;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic [BP_XLEN-1:0] npc;
  } bp_entry_t;

  function automatic logic [BP_IDXW-1:0] bp_idx(input logic [BP_XLEN-1:0] pc);
    return pc[BP_IDXW+1:2];
  endfunction

  function automatic logic [BP_TAGW-1:0] bp_tag(input logic [BP_XLEN-1:0] pc);
    return pc[BP_IDXW+BP_TAGW+1:BP_IDXW+2];
  endfunction
endpackage

// File: rtl/m_bp_queue.sv
// In-order FIFO of in-flight predictions with whole-queue flush.
// Caller must not push when full unless it pops in the same cycle.
module m_bp_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    cnt_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[head_q];
  assign cnt_o   = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q] <= din_i;
  end
endmodule

// File: rtl/m_bp_fetch.sv
// Fetch-side bimodal branch prediction control: BTB lookup, next-PC
// selection, in-flight tracking, counter-table training and redirect.
module m_bp_fetch
  import m_bp_pkg::*;
#(
  parameter int XLEN   = BP_XLEN,
  parameter int IDXW   = BP_IDXW,
  parameter int TAGW   = BP_TAGW,
  parameter int QDEPTH = BP_QDEPTH,
  localparam int CW    = $clog2(QDEPTH) + 1,
  localparam int NENT  = 1 << IDXW
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_f_valid,
  input  logic [XLEN-1:0] w_f_pc,
  output logic            w_f_ready,
  output logic [IDXW-1:0] w_radr,
  input  logic            w_pred,
  output logic [XLEN-1:0] w_npc,
  output logic            w_pred_tkn,
  input  logic            w_r_valid,
  input  logic            w_r_is_br,
  input  logic            w_r_tkn,
  input  logic [XLEN-1:0] w_r_tgt,
  output logic [IDXW-1:0] w_wadr,
  output logic            w_we,
  output logic            w_tkn,
  output logic            w_redirect,
  output logic [XLEN-1:0] w_redirect_pc,
  output logic [CW-1:0]   w_q_cnt,
  output logic            w_err
);
  logic [NENT-1:0] btb_vld_q;
  logic [TAGW-1:0] btb_tag_q [NENT];
  logic [XLEN-1:0] btb_tgt_q [NENT];

  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            err_q, err_d;

  logic [IDXW-1:0] f_idx, r_idx;
  logic            hit, push, pop, mispred, btb_we, q_full, q_empty;
  logic [XLEN-1:0] actual;
  bp_entry_t       enq, head;

  assign f_idx      = bp_idx(w_f_pc);
  assign hit        = btb_vld_q[f_idx] & (btb_tag_q[f_idx] == bp_tag(w_f_pc));
  assign w_radr     = f_idx;
  assign w_pred_tkn = hit & w_pred;
  assign w_npc      = w_pred_tkn ? btb_tgt_q[f_idx] : w_f_pc + XLEN'(4);

  assign w_f_ready  = ~redirect_q & (~q_full | w_r_valid);
  assign push       = w_f_valid & w_f_ready;
  assign enq        = '{pc: w_f_pc, npc: w_npc};

  assign pop        = w_r_valid & ~q_empty;
  assign actual     = (w_r_is_br & w_r_tkn) ? w_r_tgt : head.pc + XLEN'(4);
  assign mispred    = pop & (actual != head.npc);
  assign r_idx      = bp_idx(head.pc);
  assign btb_we     = pop & w_r_is_br & w_r_tkn;

  assign w_we       = pop & w_r_is_br;
  assign w_wadr     = r_idx;
  assign w_tkn      = w_r_tkn;

  assign w_redirect    = redirect_q;
  assign w_redirect_pc = redirect_pc_q;
  assign w_err         = err_q;

  m_bp_queue #(
    .WIDTH ($bits(bp_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (w_clk),
    .rst_ni  (w_rst_n),
    .push_i  (push),
    .pop_i   (w_r_valid),
    .flush_i (mispred),
    .din_i   (enq),
    .head_o  (head),
    .cnt_o   (w_q_cnt),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    redirect_d    = mispred;
    redirect_pc_d = mispred ? actual : redirect_pc_q;
    err_d         = err_q | (w_r_valid & q_empty);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      btb_vld_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (btb_we) btb_vld_q[r_idx] <= 1'b1;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
    end
  end

  // Tag comes from the branch's own PC so a later fetch of it hits.
  always_ff @(posedge w_clk) begin
    if (btb_we) begin
      btb_tag_q[r_idx] <= bp_tag(head.pc);
      btb_tgt_q[r_idx] <= w_r_tgt;
    end
  end
endmodule

// File: tb/tb_m_bp_fetch.sv
// Directed bench for m_bp_fetch: a queue/array reference model checked every
// cycle, plus hand-computed expectations at key points of the scenario.
module tb_m_bp_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid, pred, r_valid, r_is_br, r_tkn;
  logic [31:0] f_pc, r_tgt;
  logic        w_f_ready, w_pred_tkn, w_we, w_tkn, w_redirect, w_err;
  logic [4:0]  w_radr, w_wadr;
  logic [31:0] w_npc, w_redirect_pc;
  logic [2:0]  w_q_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  m_bp_fetch dut (
    .w_clk         (clk),
    .w_rst_n       (rst_n),
    .w_f_valid     (f_valid),
    .w_f_pc        (f_pc),
    .w_f_ready     (w_f_ready),
    .w_radr        (w_radr),
    .w_pred        (pred),
    .w_npc         (w_npc),
    .w_pred_tkn    (w_pred_tkn),
    .w_r_valid     (r_valid),
    .w_r_is_br     (r_is_br),
    .w_r_tkn       (r_tkn),
    .w_r_tgt       (r_tgt),
    .w_wadr        (w_wadr),
    .w_we          (w_we),
    .w_tkn         (w_tkn),
    .w_redirect    (w_redirect),
    .w_redirect_pc (w_redirect_pc),
    .w_q_cnt       (w_q_cnt),
    .w_err         (w_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: BTB as plain arrays indexed by (pc/4)%32, tag (pc/128)%256.
  typedef struct { logic [31:0] pc; logic [31:0] npc; } ent_t;
  ent_t        m_q[$];
  bit          m_vld[32];
  int unsigned m_tag[32];
  logic [31:0] m_tgt[32];
  bit          m_redir = 0;
  logic [31:0] m_rpc   = 0;
  bit          m_err   = 0;

  function automatic void predict(input logic [31:0] pc, input bit p,
                                  output bit tk, output logic [31:0] np);
    int unsigned i;
    i  = (pc / 4) % 32;
    tk = p && m_vld[i] && (m_tag[i] == (pc / 128) % 256);
    np = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit          tk, ready, mis;
    logic [31:0] np, act;
    ent_t        h;
    if (!rst_n) begin
      m_q.delete();
      foreach (m_vld[i]) m_vld[i] = 0;
      m_redir = 0;
      m_rpc   = 0;
      m_err   = 0;
    end else begin
      predict(f_pc, pred, tk, np);
      ready = !m_redir && (m_q.size() < 4 || r_valid);
      mis   = 0;
      if (r_valid && m_q.size() == 0) m_err = 1;
      if (r_valid && m_q.size() > 0) begin
        h   = m_q.pop_front();
        act = (r_is_br && r_tkn) ? r_tgt : h.pc + 32'd4;
        mis = (act != h.npc);
        if (r_is_br && r_tkn) begin
          m_vld[(h.pc / 4) % 32] = 1;
          m_tag[(h.pc / 4) % 32] = (h.pc / 128) % 256;
          m_tgt[(h.pc / 4) % 32] = r_tgt;
        end
      end
      if (f_valid && ready) m_q.push_back('{pc: f_pc, npc: np});
      if (mis) begin
        m_q.delete();
        m_rpc = act;
      end
      m_redir = mis;
    end
  end

  always @(negedge clk) begin : compare
    bit          tk, we_exp;
    logic [31:0] np;
    predict(f_pc, pred, tk, np);
    chk("m_ready", w_f_ready, !m_redir && (m_q.size() < 4 || r_valid));
    chk("m_radr", w_radr, (f_pc / 4) % 32);
    chk("m_npc", w_npc, np);
    chk("m_ptkn", w_pred_tkn, tk);
    we_exp = r_valid && m_q.size() > 0 && r_is_br;
    chk("m_we", w_we, we_exp);
    if (we_exp) begin
      chk("m_wadr", w_wadr, (m_q[0].pc / 4) % 32);
      chk("m_tkn", w_tkn, r_tkn);
    end
    chk("m_redir", w_redirect, m_redir);
    if (m_redir) chk("m_rpc", w_redirect_pc, m_rpc);
    chk("m_cnt", w_q_cnt, m_q.size());
    chk("m_err", w_err, m_err);
  end

  task automatic drv(input bit fv, input logic [31:0] pc, input bit p,
                     input bit rv, input bit br, input bit tk, input logic [31:0] tgt);
    f_valid = fv; f_pc = pc; pred = p;
    r_valid = rv; r_is_br = br; r_tkn = tk; r_tgt = tgt;
  endtask

  task automatic cyc(input bit fv, input logic [31:0] pc, input bit p,
                     input bit rv, input bit br, input bit tk, input logic [31:0] tgt);
    @(posedge clk); #1;
    drv(fv, pc, p, rv, br, tk, tgt);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cnt", w_q_cnt, 0);
    chk("rst_redir", w_redirect, 0);
    chk("rst_rpc", w_redirect_pc, 0);
    chk("rst_err", w_err, 0);

    // Cold miss, then taken resolve trains the BTB and redirects.
    cyc(1, 32'h100, 1, 0, 0, 0, 0);
    chk("miss_npc", w_npc, 32'h104);
    chk("miss_ptkn", w_pred_tkn, 0);
    chk("miss_radr", w_radr, 0);
    chk("miss_ready", w_f_ready, 1);
    cyc(0, 0, 0, 1, 1, 1, 32'h200);
    chk("r1_cnt", w_q_cnt, 1);
    chk("r1_we", w_we, 1);
    chk("r1_wadr", w_wadr, 0);
    chk("r1_tkn", w_tkn, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("r1_redir", w_redirect, 1);
    chk("r1_rpc", w_redirect_pc, 32'h200);
    chk("r1_cnt0", w_q_cnt, 0);
    chk("r1_ready", w_f_ready, 0);

    // Hit and correct taken resolve.
    cyc(1, 32'h100, 1, 0, 0, 0, 0);
    chk("hit_npc", w_npc, 32'h200);
    chk("hit_ptkn", w_pred_tkn, 1);
    cyc(0, 0, 0, 1, 1, 1, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("ok_redir", w_redirect, 0);
    chk("ok_cnt", w_q_cnt, 0);

    // Fill the queue, then simultaneous enqueue/dequeue at full.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h300 + 32'(4 * i), 0, 0, 0, 0, 0);
      chk("fill_ready", w_f_ready, 1);
    end
    cyc(1, 32'h310, 0, 0, 0, 0, 0);
    chk("full_ready", w_f_ready, 0);
    chk("full_cnt", w_q_cnt, 4);
    cyc(1, 32'h310, 0, 1, 0, 0, 0);
    chk("swap_ready", w_f_ready, 1);
    chk("swap_we", w_we, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("swap_cnt", w_q_cnt, 4);
    chk("swap_redir", w_redirect, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drain_cnt", w_q_cnt, 0);
    chk("drain_redir", w_redirect, 0);

    // Predicted taken, resolved not-taken with two younger entries.
    cyc(1, 32'h100, 1, 0, 0, 0, 0);
    chk("pt_npc", w_npc, 32'h200);
    cyc(1, 32'h200, 0, 0, 0, 0, 0);
    chk("y1_npc", w_npc, 32'h204);
    cyc(1, 32'h204, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 32'h0);
    chk("nt_cnt", w_q_cnt, 3);
    chk("nt_we", w_we, 1);
    chk("nt_tkn", w_tkn, 0);
    chk("nt_wadr", w_wadr, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("nt_redir", w_redirect, 1);
    chk("nt_rpc", w_redirect_pc, 32'h104);
    chk("nt_cnt0", w_q_cnt, 0);
    cyc(1, 32'h100, 1, 0, 0, 0, 0);
    chk("kept_npc", w_npc, 32'h200);
    chk("kept_ptkn", w_pred_tkn, 1);
    cyc(0, 0, 0, 1, 1, 1, 32'h200);

    // Mispredict flushes a same-cycle enqueue; same-index read sees old BTB.
    cyc(1, 32'h400, 0, 0, 0, 0, 0);
    chk("f400_npc", w_npc, 32'h404);
    cyc(1, 32'h100, 1, 1, 1, 1, 32'h500);
    chk("old_npc", w_npc, 32'h200);
    chk("old_ptkn", w_pred_tkn, 1);
    chk("w400_we", w_we, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("fl_redir", w_redirect, 1);
    chk("fl_rpc", w_redirect_pc, 32'h500);
    chk("fl_cnt", w_q_cnt, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h100, 1, 0, 0, 0, 0);
    chk("new_npc", w_npc, 32'h104);
    chk("new_ptkn", w_pred_tkn, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // Resolve with empty queue.
    cyc(0, 0, 0, 1, 1, 1, 32'h700);
    chk("emp_we", w_we, 0);
    chk("emp_cnt", w_q_cnt, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("err_set", w_err, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("err_hold", w_err, 1);

    // Reset mid-queue.
    cyc(1, 32'h600, 0, 0, 0, 0, 0);
    cyc(1, 32'h604, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", w_q_cnt, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_cnt", w_q_cnt, 0);
    chk("mrst_err", w_err, 0);
    chk("mrst_redir", w_redirect, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(1, 32'h100, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_npc", w_npc, 32'h104);
    chk("post_ptkn", w_pred_tkn, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_cnt", w_q_cnt, 1);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
